// File: rtl/exc_pkg.sv
// Shared constants for the exception sequencer: CP0 cause codes, Status bit
// positions and FSM state encoding. Optional feature macro: EXC_EXT_INT_EN.
package exc_pkg;

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
  localparam logic [4:0] CAUSE_INT     = 5'b00000;

  localparam int ST_IE  = 0;
  localparam int ST_SYS = 1;
  localparam int ST_BRK = 2;
  localparam int ST_TEQ = 3;
  localparam int ST_INT = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXC    = 2'd1;
  localparam logic [1:0] S_ERET   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: masks trap/ERET/interrupt requests with the
// low Status bits and picks one winner (SYSCALL > BREAK > TEQ > ERET > INT).
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       instr_valid,
  input  logic       syscall,
  input  logic       brk,
  input  logic       teq_taken,
  input  logic       eret_instr,
  input  logic       int_any,
  input  logic [4:0] status,
  output logic       accept_exc,
  output logic       accept_eret,
  output logic [4:0] cause,
  output logic       epc_next
);

  logic ok_sys;
  logic ok_brk;
  logic ok_teq;
  logic ok_eret;
  logic ok_int;

  // Masked traps simply lose; a lower-priority enabled trap can still win.
  assign ok_sys  = instr_valid & syscall   & status[ST_IE] & status[ST_SYS];
  assign ok_brk  = instr_valid & brk       & status[ST_IE] & status[ST_BRK];
  assign ok_teq  = instr_valid & teq_taken & status[ST_IE] & status[ST_TEQ];
  assign ok_eret = instr_valid & eret_instr;
  assign ok_int  = int_any & status[ST_IE] & status[ST_INT];

  always_comb begin
    accept_exc  = 1'b0;
    accept_eret = 1'b0;
    cause       = CAUSE_INT;
    epc_next    = 1'b0;
    if (ok_sys) begin
      accept_exc = 1'b1;
      cause      = CAUSE_SYSCALL;
    end else if (ok_brk) begin
      accept_exc = 1'b1;
      cause      = CAUSE_BREAK;
    end else if (ok_teq) begin
      accept_exc = 1'b1;
      cause      = CAUSE_TEQ;
    end else if (ok_eret) begin
      accept_eret = 1'b1;
    end else if (ok_int) begin
      accept_exc = 1'b1;
      epc_next   = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer driving CP0 exception/eret strobes and a CPU
// stall. External interrupt path is present only with EXC_EXT_INT_EN defined.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_INT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic               instr_done,
  input  logic               syscall,
  input  logic               brk,
  input  logic               teq_taken,
  input  logic               eret_instr,
  input  logic [NUM_INT-1:0] int_req,
  input  logic [31:0]        status,
  output logic               exception,
  output logic               eret,
  output logic [4:0]         cause,
  output logic               epc_next,
  output logic [NUM_INT-1:0] int_id,
  output logic               stall
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [4:0] cause_reg;
  logic       int_any;
  logic       accept_exc;
  logic       accept_eret;
  logic [4:0] acc_cause;
  logic       acc_epc_next;
  logic       in_idle;
  logic       unused_status;

  assign unused_status = ^status[31:5];
  assign in_idle       = (state_reg == S_IDLE);

  exc_prio_enc u_prio (
    .instr_valid (instr_valid),
    .syscall     (syscall),
    .brk         (brk),
    .teq_taken   (teq_taken),
    .eret_instr  (eret_instr),
    .int_any     (int_any),
    .status      (status[4:0]),
    .accept_exc  (accept_exc),
    .accept_eret (accept_eret),
    .cause       (acc_cause),
    .epc_next    (acc_epc_next)
  );

  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE: begin
        if (accept_exc)       state_next = S_EXC;
        else if (accept_eret) state_next = S_ERET;
        else                  state_next = S_IDLE;
      end
      S_EXC:    state_next = S_SETTLE;
      S_ERET:   state_next = S_SETTLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cause_reg <= 5'd0;
    end else begin
      state_reg <= state_next;
      if (in_idle && accept_exc) cause_reg <= acc_cause;
    end
  end

`ifdef EXC_EXT_INT_EN
  logic               epc_next_reg;
  logic [NUM_INT-1:0] int_id_reg;

  assign int_any = instr_done & (|int_req);

  // Traps clear the interrupt snapshot so int_id never shows a stale source.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_next_reg <= 1'b0;
      int_id_reg   <= '0;
    end else if (in_idle && accept_exc) begin
      epc_next_reg <= acc_epc_next;
      int_id_reg   <= acc_epc_next ? int_req : '0;
    end
  end

  assign epc_next = epc_next_reg;
  assign int_id   = int_id_reg;
`else
  logic unused_int;

  assign int_any    = 1'b0;
  assign unused_int = ^{int_req, instr_done, acc_epc_next};
  assign epc_next   = 1'b0;
  assign int_id     = '0;
`endif

  assign exception = (state_reg == S_EXC);
  assign eret      = (state_reg == S_ERET);
  assign stall     = ~in_idle;
  assign cause     = cause_reg;

endmodule
